// File: rtl/addsub_arb2_pkg.sv
// Shared constants and types for the two-requester add/subtract arbiter.
// Imported by the arbiter top and its combinational adder.
package addsub_arb2_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic             op;
    logic             id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } operand_t;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/addsub_arb2_addsub32.sv
// Purely combinational add/subtract unit: result, carry (no-borrow on sub) and
// signed overflow. Subtraction is a + ~b + 1 so one adder serves both ops.
module addsub32
  import addsub_arb2_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;

  // Single adder with conditional operand inversion and carry-in
  always_comb begin
    if (op == OP_SUB) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    sum_s    = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, op};
    result   = sum_s[WIDTH-1:0];
    carry    = sum_s[WIDTH];
    overflow = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_arb2.sv
// Round-robin arbiter and sequencer in front of one shared add/subtract unit.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module addsub_arb2
  import addsub_arb2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_overflow,
  output logic             resp_zero
);

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             last_r;
  operand_t         opnd_r;
  operand_t         grant_opnd_s;
  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_carry_s;
  logic             alu_overflow_s;

  // Grant selection: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Operand mux feeding the operand registers on handshake
  always_comb begin
    grant_opnd_s.id = grant_id_s;
    if (grant_id_s) begin
      grant_opnd_s.op = req1_op;
      grant_opnd_s.a  = req1_a;
      grant_opnd_s.b  = req1_b;
    end else begin
      grant_opnd_s.op = req0_op;
      grant_opnd_s.a  = req0_a;
      grant_opnd_s.b  = req0_b;
    end
  end

  assign accept_s = (state_r == IDLE) && grant_valid_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: ready only to the granted requester while idle
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (state_r)
      IDLE: begin
        req0_ready = grant_valid_s && (grant_id_s == 1'b0);
        req1_ready = grant_valid_s && (grant_id_s == 1'b1);
      end
      EXEC: resp_valid = 1'b0;
      RESP: resp_valid = 1'b1;
      default: resp_valid = 1'b0;
    endcase
  end

  addsub32 u_addsub32 (
    .a        (opnd_r.a),
    .b        (opnd_r.b),
    .op       (opnd_r.op),
    .result   (alu_result_s),
    .carry    (alu_carry_s),
    .overflow (alu_overflow_s)
  );

  // Operand capture on handshake; `last` resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd_r.op <= OP_ADD;
      opnd_r.id <= 1'b0;
      opnd_r.a  <= {WIDTH{1'b0}};
      opnd_r.b  <= {WIDTH{1'b0}};
      last_r    <= 1'b1;
    end else if (accept_s) begin
      opnd_r    <= grant_opnd_s;
      last_r    <= grant_id_s;
    end else begin
      opnd_r    <= opnd_r;
      last_r    <= last_r;
    end
  end

  // Response capture in EXEC; held untouched through RESP backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_id       <= 1'b0;
      resp_result   <= {WIDTH{1'b0}};
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_id       <= opnd_r.id;
      resp_result   <= alu_result_s;
      resp_carry    <= alu_carry_s;
      resp_overflow <= alu_overflow_s;
      resp_zero     <= is_zero(alu_result_s);
    end else begin
      resp_id       <= resp_id;
      resp_result   <= resp_result;
      resp_carry    <= resp_carry;
      resp_overflow <= resp_overflow;
      resp_zero     <= resp_zero;
    end
  end

endmodule

// File: doc/addsub_arb2.md
# addsub_arb2

Two-requester arbiter and sequencer for a shared 32-bit add/subtract datapath. Each requester presents an operation (add or sub) with two operands over a valid/ready handshake. The block grants one requester at a time, round-robin, and runs the operation through a single adder instance. It returns the result with carry, overflow and zero flags on one response channel tagged with the requester id. It sits between the two operand sources and the shared adder resource in the experiment datapath.

## Interface
- WIDTH, 32, operand and result width.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&ready.
- req0_op / req1_op  in  1  0 = add (a+b), 1 = sub (a-b).
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands; no signed/unsigned interpretation, flags cover both.
- resp_valid  out  1  response held until resp_ready.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the operation.
- resp_result  out  WIDTH  sum or difference, mod 2^WIDTH.
- resp_carry  out  1  add: carry out; sub: 1 = no borrow (a >= b unsigned).
- resp_overflow  out  1  signed overflow.
- resp_zero  out  1  resp_result == 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Grant is computed combinationally from req*_valid and the priority pointer `last`.
  - Only the granted requester sees ready=1; the other sees ready=0.
  - When only one requester is valid, it is granted.
  - When both are valid, the one != `last` is granted.
  - On handshake: latch op, a, b and id into operand registers, set `last` = id, go to EXEC.
- EXEC: the datapath computes from the operand registers. Latch result and flags into the response registers. Go to RESP.
- RESP: resp_valid=1. On resp_ready=1, go to IDLE. The response registers are stable while resp_valid=1 and resp_ready=0.
- req*_ready=0 in EXEC and RESP; there is no queuing.
- Arithmetic: sum = a + (b ^ {WIDTH{op}}) + op, WIDTH+1 bits wide.
  - carry = sum[WIDTH].
  - overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted b for sub.
- req*_ready may depend combinationally on req*_valid. Requesters must not make valid depend on ready.
- A requester may drop valid without a handshake; no state changes.

## Timing
- Handshake at edge N. EXEC is cycle N+1. resp_valid=1 from cycle N+2.
- Minimum spacing between accepted operations is 3 cycles when resp_ready is held at 1.
- resp_valid&resp_ready at edge M: req ready can be 1 in cycle M+1.
- Reset values:
  - state = IDLE.
  - resp_valid = 0; resp_id = 0; resp_result = 0; all flags = 0.
  - req*_ready = 0 unless the request is valid and granted in IDLE.
  - `last` = 1, so requester 0 wins the first tie.
- Reset asserted in EXEC or RESP: on the next edge return to IDLE, drop the in-flight operation, and deassert resp_valid. No response is produced.
- The operation latched during EXEC is unaffected by changes on the req inputs after the handshake.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - op constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, `addsub32`, is purely combinational: a, b and op in; result, carry and overflow out. It is instanced once; the parent controls arbitration, FSM and registers. Zero is derived in the parent.

## Test plan
- **Add:** req0 add 5+3 → resp_id=0, result=8, carry=0, ovf=0, zero=0, resp_valid 2 cycles after the handshake.
- **Signed overflow:** req1 add 0x7FFFFFFF+0x00000001 → result=0x80000000, ovf=1, carry=0, id=1.
- **Sub, unsigned wrap and zero:**
  - req0 sub 3-5 → 0xFFFFFFFE, carry=0, ovf=0.
  - req0 sub 5-5 → 0, carry=1, zero=1.
- **Tie and round-robin:** both valid continuously from reset, resp_ready=1 → ids in the order 0,1,0,1. Each operation is accepted 3 cycles apart; the losing ready stays 0.
- **Backpressure:** resp_ready=0 for 5 cycles during RESP → resp_valid and data held constant; both req ready=0. Release → IDLE, next grant one cycle later.
- **Reset during EXEC:** rst_n=0 for one cycle → resp_valid stays 0, state IDLE, and the next tie is granted to requester 0.
